div_unit: RTL and testbench
===========================

# div_unit

Iterative 32-bit radix-2 restoring divider in the EX stage of the MIPS pipeline, serving DIV/DIVU. While it is busy it drives `stall`, which the hazard logic inverts into the `en` inputs of the upstream pipeline and PC enable-flops. On completion it presents quotient and remainder for one cycle, for capture into HI/LO.

## Interface
- `WIDTH`, default 32: operand, quotient and remainder width. Must be even and ≥ 4.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request a divide. Sampled only in IDLE.
- `signed_i`  in  1: 1 = DIV (two's complement), 0 = DIVU. Sampled with `start`.
- `a`  in  WIDTH: dividend. Sampled with `start`.
- `b`  in  WIDTH: divisor. Sampled with `start`.
- `annul`  in  1: pipeline flush. Cancels any operation in flight.
- `stall`  out  1: pipeline must hold. Combinational.
- `valid`  out  1: `q`/`r` are valid this cycle. Single-cycle pulse.
- `q`  out  WIDTH: quotient. Registered.
- `r`  out  WIDTH: remainder. Registered.

## Operation
States:
- IDLE: waits for `start`.
- BUSY: runs WIDTH iterations, counted 0..WIDTH-1.
- FIX: applies sign correction.
- DONE: presents the result.

Transitions:
- IDLE→BUSY when `start && !annul`. Registers operand magnitudes: abs(a) and abs(b) when signed, raw values otherwise. Registers result signs: sign(q) = a[MSB]^b[MSB], sign(r) = a[MSB]. Registers zflag = (b == 0). Clears the partial remainder and the counter.
- BUSY: each cycle performs one shift/trial-subtract/restore step and increments the counter. BUSY→FIX after the iteration with counter = WIDTH-1.
- FIX: negates q and/or r according to the recorded signs. If zflag is set, forces q = all-ones and r = original `a` (raw bits), with no sign correction. Then goes to DONE.
- DONE→IDLE unconditionally. `valid` = 1 only in DONE.

Outputs:
- `stall` = (IDLE && `start` && !`annul`) || BUSY || FIX. It is deasserted in DONE, so the stalled instruction advances in the same cycle it captures `q`/`r`.
- `q` and `r` hold their last values outside DONE.

Arithmetic:
- Partial remainder is WIDTH+1 bits wide to hold the trial-subtraction borrow.
- Signed overflow (most-negative / -1) needs no special case and yields q = most-negative, r = 0.

Boundary conditions:
- `annul` in BUSY, FIX or DONE: next state is IDLE and `valid` stays 0. `annul` in DONE suppresses `valid` combinationally.
- `start` outside IDLE is ignored. A `start` in the DONE cycle is not accepted; it must be presented again in IDLE.
- Reset, including mid-operation: state = IDLE, counter = 0, `q` = 0, `r` = 0, `valid` = 0, `stall` = 0.

## Timing
- Cycle 0: IDLE with `start` high. `stall` is already high.
- Cycles 1..WIDTH: BUSY.
- Cycle WIDTH+1: FIX.
- Cycle WIDTH+2: DONE, `valid` = 1. This is cycle 34 for WIDTH = 32.
- `stall` is high for WIDTH+2 cycles, from cycle 0 through cycle WIDTH+1.
- Minimum start-to-start spacing is WIDTH+3 cycles.
- Divide-by-zero has the same latency as a normal divide.

## Configuration
- `DIV_SIGNED_EN` defined: `signed_i` is honoured. Abs/negate logic and the signed fixup in FIX are compiled in.
- `DIV_SIGNED_EN` undefined: `signed_i` is ignored and every operation is DIVU. FIX only applies the divide-by-zero override. Latency is unchanged.

## Structure
- Shared package `cpu_pkg`:
  - `div_state_t` enum (IDLE, BUSY, FIX, DONE).
  - `DIV_CNT_W` = $clog2(WIDTH) localparam helper.
- Sub-module `div_step`: one combinational restoring iteration.
  - Inputs: partial remainder and next dividend bit.
  - Outputs: new partial remainder and quotient bit.
  - Instantiated once and reused every BUSY cycle.

## Test plan
- DIVU a = 100, b = 7: `stall` high cycles 0–33; `valid` at cycle 34 with q = 14, r = 2; `stall` low in cycle 34.
- DIV a = 0xFFFFFFF9 (−7), b = 2: q = 0xFFFFFFFD (−3), r = 0xFFFFFFFF (−1). Without `DIV_SIGNED_EN`: q = 0x7FFFFFFC, r = 1.
- DIVU a = 5, b = 0: `valid` at cycle 34 with q = 0xFFFFFFFF, r = 5.
- DIV a = 0x80000000, b = 0xFFFFFFFF: q = 0x80000000, r = 0.
- `annul` pulsed in cycle 10: IDLE and `stall` = 0 in cycle 11; no `valid`. A new `start` in cycle 11 gives `valid` in cycle 45.
- `rst_n` driven low in cycle 20: `stall`, `valid`, `q` and `r` go to 0 immediately. After release, `start` in IDLE behaves normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: divider state encoding and counter-width helper.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    function automatic int div_cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract, restore on borrow.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    always_comb begin
        shifted = {rem_in, dvd_bit};
        diff    = shifted - {2'b00, divisor};
        q_bit   = ~diff[WIDTH+1];
        rem_out = diff[WIDTH+1] ? shifted[WIDTH:0] : diff[WIDTH:0];
    end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU with pipeline stall/annul handshake.
// Define DIV_SIGNED_EN to honour signed_i; otherwise every operation is unsigned.
module div_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             annul,
    output logic             stall,
    output logic             valid,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r
);

    localparam int DIV_CNT_W = div_cnt_w(WIDTH);
    localparam logic [DIV_CNT_W-1:0] CNT_LAST = DIV_CNT_W'(WIDTH - 1);

    div_state_t           state, state_nxt;
    logic [DIV_CNT_W-1:0] cnt;
    logic [WIDTH-1:0]     dvd, dvs;
    logic [WIDTH:0]       rem, rem_step;
    logic                 q_bit, zflag, accept;
    logic [WIDTH-1:0]     a_mag, b_mag, q_fix, r_fix;

    // dvd doubles as the quotient: dividend bits shift out the top as quotient bits shift in.
    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem),
        .dvd_bit (dvd[WIDTH-1]),
        .divisor (dvs),
        .rem_out (rem_step),
        .q_bit   (q_bit)
    );

`ifdef DIV_SIGNED_EN
    logic q_neg, r_neg;

    assign a_mag = (signed_i && a[WIDTH-1]) ? -a : a;
    assign b_mag = (signed_i && b[WIDTH-1]) ? -b : b;
    assign q_fix = q_neg ? -dvd : dvd;
    // On divide-by-zero rem ends up as abs(a), so this also restores the raw dividend.
    assign r_fix = r_neg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
`else
    logic unused_signed;

    assign unused_signed = signed_i;
    assign a_mag = a;
    assign b_mag = b;
    assign q_fix = dvd;
    assign r_fix = rem[WIDTH-1:0];
`endif

    assign accept = (state == IDLE) && start && !annul;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = BUSY;
            BUSY:    if (annul) state_nxt = IDLE;
                     else if (cnt == CNT_LAST) state_nxt = FIX;
            FIX:     state_nxt = annul ? IDLE : DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        stall = 1'b0;
        valid = 1'b0;
        if (rst_n) begin
            stall = accept || (state == BUSY) || (state == FIX);
            valid = (state == DONE) && !annul;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            dvd   <= '0;
            dvs   <= '0;
            rem   <= '0;
            zflag <= 1'b0;
            q     <= '0;
            r     <= '0;
`ifdef DIV_SIGNED_EN
            q_neg <= 1'b0;
            r_neg <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        dvd   <= a_mag;
                        dvs   <= b_mag;
                        rem   <= '0;
                        cnt   <= '0;
                        zflag <= (b == '0);
`ifdef DIV_SIGNED_EN
                        q_neg <= signed_i && (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_neg <= signed_i && a[WIDTH-1];
`endif
                    end
                end
                BUSY: begin
                    dvd <= {dvd[WIDTH-2:0], q_bit};
                    rem <= rem_step;
                    cnt <= cnt + DIV_CNT_W'(1);
                end
                FIX: begin
                    if (!annul) begin
                        q <= zflag ? '1 : q_fix;
                        r <= r_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, stall window, signed/zero cases, annul, reset.
module tb_div_unit;

    localparam int W = 32;

`ifdef DIV_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif

    logic         clk, rst_n, start, signed_i, annul, stall, valid;
    logic [W-1:0] a, b, q, r;
    int           tests_run = 0;
    int           tests_failed = 0;

    div_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .signed_i (signed_i),
        .a        (a),
        .b        (b),
        .annul    (annul),
        .stall    (stall),
        .valid    (valid),
        .q        (q),
        .r        (r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Start in cycle 0, scramble operands afterwards, check stall/valid window and result.
    task automatic run_div(input string tag, input logic sgn, input logic [W-1:0] da,
                           input logic [W-1:0] db, input logic [W-1:0] eq,
                           input logic [W-1:0] er, input bit retry_in_done);
        int bad;
        bad = 0;
        cyc();
        start = 1'b1; signed_i = sgn; a = da; b = db;
        for (int c = 0; c <= W + 2; c++) begin
            if (c > 0) begin
                cyc();
                start = 1'b0; signed_i = ~sgn; a = ~da; b = ~db;
            end
            @(negedge clk);
            if (c <= W + 1 && (stall !== 1'b1 || valid !== 1'b0)) bad++;
        end
        check({tag, "_window"}, W'(bad), '0);
        check({tag, "_valid"}, W'(valid), 1);
        check({tag, "_stall_done"}, W'(stall), 0);
        check({tag, "_q"}, q, eq);
        check({tag, "_r"}, r, er);
        if (retry_in_done) start = 1'b1;
        cyc();
        start = 1'b0;
        @(negedge clk);
        check({tag, "_idle_after"}, W'({stall, valid}), 0);
    endtask

    initial begin
        int bad;
        rst_n = 1'b0; start = 1'b0; signed_i = 1'b0; annul = 1'b0; a = '0; b = '0;
        #12;
        check("reset_state", {stall, valid}, 0);
        check("reset_q", q, 0);
        check("reset_r", r, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b1);
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2,
                SIGNED_BUILD ? 32'hFFFF_FFFD : 32'h7FFF_FFFC,
                SIGNED_BUILD ? 32'hFFFF_FFFF : 32'd1, 1'b0);
        run_div("divu_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0);
        run_div("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b0);
        run_div("div_m7_0", 1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0);
        run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
                SIGNED_BUILD ? 32'h8000_0000 : 32'd0,
                SIGNED_BUILD ? 32'd0 : 32'h8000_0000, 1'b0);
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE,
                SIGNED_BUILD ? 32'hFFFF_FFFD : 32'd0,
                SIGNED_BUILD ? 32'd1 : 32'd7, 1'b0);
        run_div("divu_max_16", 1'b0, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 32'd15, 1'b0);

        // annul in cycle 10, restart in cycle 11
        cyc();
        start = 1'b1; signed_i = 1'b0; a = 32'd100; b = 32'd7;
        for (int c = 1; c <= 10; c++) begin
            cyc();
            start = 1'b0;
        end
        annul = 1'b1;
        @(negedge clk);
        check("annul_c10_valid", W'(valid), 0);
        cyc();
        annul = 1'b0;
        @(negedge clk);
        check("annul_c11_idle", W'({stall, valid}), 0);
        start = 1'b1; a = 32'd1000; b = 32'd10;
        bad = 0;
        for (int c = 12; c <= 45; c++) begin
            cyc();
            start = 1'b0;
            @(negedge clk);
            if (c < 45 && valid !== 1'b0) bad++;
        end
        check("restart_no_early_valid", W'(bad), 0);
        check("restart_valid_c45", W'(valid), 1);
        check("restart_q", q, 32'd100);
        check("restart_r", r, 32'd0);

        // annul during DONE suppresses valid
        cyc();
        start = 1'b1; a = 32'd1000; b = 32'd3;
        for (int c = 1; c <= W + 2; c++) begin
            cyc();
            start = 1'b0;
        end
        annul = 1'b1;
        @(negedge clk);
        check("annul_done_valid", W'(valid), 0);
        check("annul_done_stall", W'(stall), 0);
        cyc();
        annul = 1'b0;
        @(negedge clk);
        check("annul_done_after", W'({stall, valid}), 0);

        // asynchronous reset in cycle 20
        cyc();
        start = 1'b1; a = 32'd77; b = 32'd5;
        for (int c = 1; c <= 20; c++) begin
            cyc();
            start = 1'b0;
        end
        check("pre_reset_q_nonzero", W'(q != 0), 1);
        rst_n = 1'b0;
        #1;
        check("midop_reset_state", W'({stall, valid}), 0);
        check("midop_reset_q", q, 0);
        check("midop_reset_r", r, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_div("post_reset", 1'b0, 32'd77, 32'd5, 32'd15, 32'd2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
